// File: rtl/display_mode_sequencer.sv
// Display mode sequencer: cycles the 4-digit display through time, date and scrolling text.
// Optional night blanking is enabled with DISPLAY_NIGHT_BLANK_EN.
//
// state     | meaning
// SHOW_TIME | hh:mm with blinking colon, counts TIME_SECS seconds
// SHOW_DATE | dd.mm, counts DATE_SECS seconds, only while sync_ok
// SCROLL    | scroll text, SCROLL_LEN steps of SCROLL_DIV cycles each
`timescale 1ns/1ps
module display_mode_sequencer #(
  parameter int TIME_SECS  = 10,
  parameter int DATE_SECS  = 3,
  parameter int SCROLL_LEN = 40,
  parameter int SCROLL_DIV = 6250000
) (
  input  logic        qzt_clk,
  input  logic        reset_sincro,
  input  logic        flag_sec,
  input  logic [15:0] time_bcd,
  input  logic [15:0] date_bcd,
  input  logic        sync_ok,
  input  logic        btn_next,
`ifdef DISPLAY_NIGHT_BLANK_EN
  input  logic        night,
`endif
  output logic [15:0] four_digit,
  output logic [5:0]  loop_index,
  output logic [1:0]  disp_type
);

  typedef enum logic [1:0] {
    SHOW_TIME = 2'd0,
    SHOW_DATE = 2'd1,
    SCROLL    = 2'd2
  } state_t;

  localparam logic [5:0]  TIME_LAST   = 6'(TIME_SECS - 1);
  localparam logic [5:0]  DATE_LAST   = 6'(DATE_SECS - 1);
  localparam logic [5:0]  SCROLL_LAST = 6'(SCROLL_LEN - 1);
  localparam logic [23:0] PRESC_LAST  = 24'(SCROLL_DIV - 1);

  state_t      state_q, state_d;
  logic [5:0]  sec_cnt_q, sec_cnt_d;
  logic [23:0] presc_q, presc_d;
  logic [5:0]  loop_index_q, loop_index_d;
  logic [15:0] four_digit_q, four_digit_d;
  logic [1:0]  disp_type_q, disp_type_d;
  logic        advance;
  logic        frozen;

`ifdef DISPLAY_NIGHT_BLANK_EN
  assign frozen = night;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge qzt_clk) begin
    if (reset_sincro) begin
      state_q      <= SHOW_TIME;
      sec_cnt_q    <= 6'd0;
      presc_q      <= 24'd0;
      loop_index_q <= 6'd0;
      four_digit_q <= 16'h0000;
      disp_type_q  <= 2'd1;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      presc_q      <= presc_d;
      loop_index_q <= loop_index_d;
      four_digit_q <= four_digit_d;
      disp_type_q  <= disp_type_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    presc_d      = presc_q;
    loop_index_d = loop_index_q;
    four_digit_d = four_digit_q;
    disp_type_d  = disp_type_q;
    advance      = 1'b0;

    // btn_next has priority so a coincident second tick or scroll step cannot cause a second move
    case (state_q)
      SHOW_TIME: begin
        if (btn_next) begin
          advance = 1'b1;
        end else if (flag_sec) begin
          if (sec_cnt_q == TIME_LAST) advance = 1'b1;
          else                        sec_cnt_d = sec_cnt_q + 6'd1;
        end
      end
      SHOW_DATE: begin
        if (btn_next || !sync_ok) begin
          advance = 1'b1;
        end else if (flag_sec) begin
          if (sec_cnt_q == DATE_LAST) advance = 1'b1;
          else                        sec_cnt_d = sec_cnt_q + 6'd1;
        end
      end
      SCROLL: begin
        if (btn_next) begin
          advance = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = 24'd0;
          if (loop_index_q == SCROLL_LAST) advance = 1'b1;
          else                             loop_index_d = loop_index_q + 6'd1;
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      default: advance = 1'b1;
    endcase

    if (advance) begin
      case (state_q)
        SHOW_TIME: state_d = sync_ok ? SHOW_DATE : SCROLL;
        SHOW_DATE: state_d = SCROLL;
        default:   state_d = SHOW_TIME;
      endcase
      sec_cnt_d    = 6'd0;
      presc_d      = 24'd0;
      loop_index_d = 6'd0;
    end

    // Outputs follow the upcoming state so the registered outputs line up with state_q
    case (state_d)
      SHOW_TIME: begin
        four_digit_d = time_bcd;
        disp_type_d  = 2'd1;
      end
      SHOW_DATE: begin
        four_digit_d = date_bcd;
        disp_type_d  = 2'd0;
      end
      default: disp_type_d = 2'd2;
    endcase

    if (frozen) begin
      state_d      = state_q;
      sec_cnt_d    = sec_cnt_q;
      presc_d      = presc_q;
      loop_index_d = loop_index_q;
      four_digit_d = four_digit_q;
      disp_type_d  = 2'd3;
    end
  end

  assign four_digit = four_digit_q;
  assign loop_index = loop_index_q;
  assign disp_type  = disp_type_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed testbench for display_mode_sequencer with short timing parameters.
`timescale 1ns/1ps
module tb_display_mode_sequencer;

  logic        qzt_clk = 1'b0;
  logic        reset_sincro;
  logic        flag_sec;
  logic [15:0] time_bcd;
  logic [15:0] date_bcd;
  logic        sync_ok;
  logic        btn_next;
`ifdef DISPLAY_NIGHT_BLANK_EN
  logic        night;
`endif
  logic [15:0] four_digit;
  logic [5:0]  loop_index;
  logic [1:0]  disp_type;

  int checks = 0;
  int fails  = 0;

  display_mode_sequencer #(
    .TIME_SECS (2),
    .DATE_SECS (1),
    .SCROLL_LEN(4),
    .SCROLL_DIV(3)
  ) dut (
    .qzt_clk     (qzt_clk),
    .reset_sincro(reset_sincro),
    .flag_sec    (flag_sec),
    .time_bcd    (time_bcd),
    .date_bcd    (date_bcd),
    .sync_ok     (sync_ok),
    .btn_next    (btn_next),
`ifdef DISPLAY_NIGHT_BLANK_EN
    .night       (night),
`endif
    .four_digit  (four_digit),
    .loop_index  (loop_index),
    .disp_type   (disp_type)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge qzt_clk);
      #1;
    end
  endtask

  task automatic pulse_sec();
    flag_sec = 1'b1;
    tick(1);
    flag_sec = 1'b0;
  endtask

  task automatic pulse_btn();
    btn_next = 1'b1;
    tick(1);
    btn_next = 1'b0;
  endtask

  task automatic test_reset();
    reset_sincro = 1'b1;
    tick(3);
    checks++;
    if (four_digit !== 16'h0000) begin
      fails++; $display("FAIL reset_four_digit: got %h expected 0000", four_digit);
    end
    checks++;
    if (loop_index !== 6'd0) begin
      fails++; $display("FAIL reset_loop_index: got %0d expected 0", loop_index);
    end
    checks++;
    if (disp_type !== 2'd1) begin
      fails++; $display("FAIL reset_disp_type: got %0d expected 1", disp_type);
    end
    reset_sincro = 1'b0;
    tick(1);
    checks++;
    if (four_digit !== 16'h1245) begin
      fails++; $display("FAIL post_reset_time: got %h expected 1245", four_digit);
    end
  endtask

  task automatic test_mode_cycle();
    tick(9);
    pulse_sec();
    checks++;
    if (disp_type !== 2'd1) begin
      fails++; $display("FAIL first_sec_stays_time: got %0d expected 1", disp_type);
    end
    tick(9);
    pulse_sec();
    checks++;
    if (disp_type !== 2'd0 || four_digit !== 16'h3112) begin
      fails++; $display("FAIL enter_date: got type %0d digits %h expected type 0 digits 3112", disp_type, four_digit);
    end
    tick(9);
    pulse_sec();
    checks++;
    if (disp_type !== 2'd2 || loop_index !== 6'd0 || four_digit !== 16'h3112) begin
      fails++; $display("FAIL enter_scroll: got type %0d idx %0d digits %h expected type 2 idx 0 digits 3112",
                        disp_type, loop_index, four_digit);
    end
  endtask

  task automatic test_scroll();
    flag_sec = 1'b1;
    tick(1);
    flag_sec = 1'b0;
    tick(2);
    checks++;
    if (loop_index !== 6'd1 || disp_type !== 2'd2) begin
      fails++; $display("FAIL scroll_step1_flag_ignored: got idx %0d type %0d expected idx 1 type 2", loop_index, disp_type);
    end
    for (int i = 2; i <= 3; i++) begin
      tick(3);
      checks++;
      if (loop_index !== 6'(i)) begin
        fails++; $display("FAIL scroll_step%0d: got %0d expected %0d", i, loop_index, i);
      end
    end
    tick(2);
    checks++;
    if (disp_type !== 2'd2 || loop_index !== 6'd3) begin
      fails++; $display("FAIL scroll_last_hold: got type %0d idx %0d expected type 2 idx 3", disp_type, loop_index);
    end
    tick(1);
    checks++;
    if (disp_type !== 2'd1 || loop_index !== 6'd0 || four_digit !== 16'h1245) begin
      fails++; $display("FAIL scroll_wrap_to_time: got type %0d idx %0d digits %h expected type 1 idx 0 digits 1245",
                        disp_type, loop_index, four_digit);
    end
  endtask

  task automatic test_no_sync();
    sync_ok = 1'b0;
    tick(4);
    pulse_sec();
    tick(4);
    pulse_sec();
    checks++;
    if (disp_type !== 2'd2 || four_digit !== 16'h1245) begin
      fails++; $display("FAIL nosync_skip_date: got type %0d digits %h expected type 2 digits 1245", disp_type, four_digit);
    end
    pulse_btn();
    sync_ok = 1'b1;
    pulse_btn();
    checks++;
    if (disp_type !== 2'd0) begin
      fails++; $display("FAIL btn_to_date: got %0d expected 0", disp_type);
    end
    sync_ok = 1'b0;
    tick(1);
    checks++;
    if (disp_type !== 2'd2) begin
      fails++; $display("FAIL date_sync_lost: got %0d expected 2", disp_type);
    end
    sync_ok = 1'b1;
    pulse_btn();
    checks++;
    if (disp_type !== 2'd1) begin
      fails++; $display("FAIL btn_scroll_to_time: got %0d expected 1", disp_type);
    end
  endtask

  task automatic test_back_to_back();
    pulse_sec();
    flag_sec = 1'b1;
    btn_next = 1'b1;
    tick(1);
    flag_sec = 1'b0;
    btn_next = 1'b0;
    checks++;
    if (disp_type !== 2'd0) begin
      fails++; $display("FAIL btn_flag_single_move: got %0d expected 0", disp_type);
    end
    checks++;
    if (dut.sec_cnt_q !== 6'd0) begin
      fails++; $display("FAIL btn_flag_sec_cnt: got %0d expected 0", dut.sec_cnt_q);
    end
    pulse_btn();
    pulse_btn();
    pulse_sec();
    checks++;
    if (disp_type !== 2'd1) begin
      fails++; $display("FAIL sec_cnt_cleared_on_entry: got %0d expected 1", disp_type);
    end
    pulse_btn();
  endtask

  task automatic test_reset_mid_scroll();
    pulse_btn();
    tick(6);
    checks++;
    if (loop_index !== 6'd2 || disp_type !== 2'd2) begin
      fails++; $display("FAIL scroll_reach_idx2: got idx %0d type %0d expected idx 2 type 2", loop_index, disp_type);
    end
    reset_sincro = 1'b1;
    btn_next = 1'b1;
    tick(1);
    reset_sincro = 1'b0;
    btn_next = 1'b0;
    checks++;
    if (disp_type !== 2'd1 || loop_index !== 6'd0 || four_digit !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_scroll: got type %0d idx %0d digits %h expected type 1 idx 0 digits 0000",
                        disp_type, loop_index, four_digit);
    end
    tick(1);
    checks++;
    if (disp_type !== 2'd1 || four_digit !== 16'h1245) begin
      fails++; $display("FAIL resume_after_reset: got type %0d digits %h expected type 1 digits 1245", disp_type, four_digit);
    end
  endtask

`ifdef DISPLAY_NIGHT_BLANK_EN
  task automatic test_night();
    pulse_btn();
    pulse_btn();
    tick(3);
    night = 1'b1;
    tick(1);
    checks++;
    if (disp_type !== 2'd3 || loop_index !== 6'd1) begin
      fails++; $display("FAIL night_blank: got type %0d idx %0d expected type 3 idx 1", disp_type, loop_index);
    end
    btn_next = 1'b1;
    tick(20);
    btn_next = 1'b0;
    checks++;
    if (disp_type !== 2'd3 || loop_index !== 6'd1) begin
      fails++; $display("FAIL night_frozen: got type %0d idx %0d expected type 3 idx 1", disp_type, loop_index);
    end
    night = 1'b0;
    tick(1);
    checks++;
    if (disp_type !== 2'd2 || loop_index !== 6'd1) begin
      fails++; $display("FAIL night_resume: got type %0d idx %0d expected type 2 idx 1", disp_type, loop_index);
    end
    tick(2);
    checks++;
    if (loop_index !== 6'd2) begin
      fails++; $display("FAIL night_resume_step: got %0d expected 2", loop_index);
    end
  endtask
`endif

  initial begin
    reset_sincro = 1'b1;
    flag_sec     = 1'b0;
    btn_next     = 1'b0;
    sync_ok      = 1'b1;
    time_bcd     = 16'h1245;
    date_bcd     = 16'h3112;
`ifdef DISPLAY_NIGHT_BLANK_EN
    night        = 1'b0;
`endif
    test_reset();
    test_mode_cycle();
    test_scroll();
    test_no_sync();
    test_back_to_back();
    test_reset_mid_scroll();
`ifdef DISPLAY_NIGHT_BLANK_EN
    test_night();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
